lb_reg_bank: RTL
================

// Module: lb_reg_bank
// PURPOSE
//  Local-bus register bank for the UDP memory gateway's addr/strobe/rd/data bus.
//  Provides RW control registers, RO status words, a sticky W1C event register with mask and IRQ, and an ID word.
//  Read data returns at a fixed latency that matches the gateway's compile-time read pipe length.
// PARAMETERS
//  base_addr    16'h0000     must equal lb_addr[23:8] for this bank to decode
//  read_latency 3            cycles from strobe cycle to lb_rdata valid; legal range 1..8
//  n_rw         16           number of RW registers, 1..16
//  n_ro         16           number of RO status words, 1..16
//  id_word      32'h4C425231 constant value returned at offset 0x22
// PORTS
//  clk         in   1         system clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  lb_addr     in   24        bus address; [23:8] selects bank, [7:0] is the offset
//  lb_strobe   in   1         one-cycle transaction strobe
//  lb_rd       in   1         1=read, 0=write; qualified by lb_strobe
//  lb_wdata    in   32        write data, valid with lb_strobe
//  lb_rdata    out  32        read data, valid read_latency cycles after the strobe
//  lb_rvalid   out  1         high in the cycle lb_rdata is valid
//  rw_out      out  32*n_rw   RW register contents; reg k at [32k+31:32k]
//  wr_pulse    out  n_rw      one-cycle pulse after a write to RW reg k
//  ro_in       in   32*n_ro   status inputs; word k at [32k+31:32k]
//  event_in    in   32        event bits; each bit sets a sticky bit
//  irq         out  1         registered |(sticky & mask)
// BEHAVIOUR
//  Reset (async assert, sync use): all RW regs=0, sticky=0, mask=0, wr_pulse=0,
//   irq=0, lb_rdata=0, lb_rvalid=0, read pipeline flushed.
//  A reset asserted mid-read drops that read; lb_rvalid is never raised for it.
//  Decode: hit = lb_strobe & (lb_addr[23:8]==base_addr). Offset map:
//   0x00+k (k<n_rw) RW reg k | 0x10+k (k<n_ro) RO word k | 0x20 sticky (W1C)
//   0x21 mask (RW) | 0x22 id_word (RO) | all other offsets read 0, writes ignored.
//  Write (hit & ~lb_rd): the target register updates at the clock edge that ends the strobe cycle.
//   - wr_pulse[k] is high for exactly the next cycle.
//   - Writes to RO, ID or unmapped offsets have no effect.
//   - Writes with no bank hit have no effect.
//  Sticky: sticky <= (sticky & ~clr) | event_in, where clr = lb_wdata on a write to 0x20, else 0.
//   - When a clear and an event hit the same bit in the same cycle, the set wins.
//  irq: registered; lags a sticky/mask change by 1 cycle.
//  Read (hit & lb_rd): the selected value is sampled at the edge ending the strobe cycle (stage 1).
//   - The value is then delayed by read_latency-1 further registers.
//   - Strobe in cycle 0 -> lb_rdata/lb_rvalid valid in cycle read_latency, for exactly 1 cycle.
//   - The pipeline accepts one read per cycle, back-to-back, with no stalls.
//   - A read of RO word k returns ro_in at the strobe cycle; no extra synchronisation.
//   - lb_rdata holds its last value when lb_rvalid=0.
//   - A read with no bank hit gives lb_rvalid=0.
//  Reads have no side effects; in particular, reading the sticky register does not clear it.
//  A read to a RW reg one cycle after a write to it returns the new value.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> all outputs 0; after release, read 0x22 -> lb_rdata=32'h4C425231 at cycle+3, lb_rvalid 1 cycle.
//  2 Write 0x05=32'hCAFEF00D -> wr_pulse=16'h0020 for 1 cycle, rw_out[191:160]=CAFEF00D; next-cycle read 0x05 returns CAFEF00D.
//  3 Back-to-back reads 0x10,0x11,0x40 with ro_in words A,B -> A,B,0 on 3 consecutive lb_rvalid cycles; no bank hit (addr 24'h010010) -> no rvalid.
//  4 event_in=32'h1 pulse; mask=1 -> irq=1 one cycle later; write 0x20=1 same cycle as event_in=1 -> sticky stays 1; write 0x20=1 alone -> irq falls.
//  5 Write to 0x12 and 0x7F -> rw_out, mask and sticky unchanged, wr_pulse stays 0.
//  6 Assert rst_n=0 one cycle after a read strobe -> lb_rvalid never asserts for that read; read_latency=1 build returns data the cycle after the strobe.

Source files
------------

// File: rtl/lb_reg_bank.sv
// Local-bus register bank: RW control regs, RO status words, sticky W1C events with mask/IRQ, ID word.
// Latency: writes land at the edge ending the strobe cycle; read data appears read_latency cycles after the strobe.
// Backpressure: none; one transaction per cycle is accepted back-to-back with no stalls.
module lb_reg_bank #(
  parameter logic [15:0] base_addr    = 16'h0000,
  parameter int          read_latency = 3,
  parameter int          n_rw         = 16,
  parameter int          n_ro         = 16,
  parameter logic [31:0] id_word      = 32'h4C425231
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [23:0]          lb_addr,
  input  logic                 lb_strobe,
  input  logic                 lb_rd,
  input  logic [31:0]          lb_wdata,
  output logic [31:0]          lb_rdata,
  output logic                 lb_rvalid,
  output logic [32*n_rw-1:0]   rw_out,
  output logic [n_rw-1:0]      wr_pulse,
  input  logic [32*n_ro-1:0]   ro_in,
  input  logic [31:0]          event_in,
  output logic                 irq
);

  localparam logic [7:0] off_sticky = 8'h20;
  localparam logic [7:0] off_mask   = 8'h21;
  localparam logic [7:0] off_id     = 8'h22;

  logic              hit;
  logic              wr_hit;
  logic              rd_hit;
  logic [7:0]        offset;
  logic [31:0]       rw_q [n_rw];
  logic [31:0]       sticky_q;
  logic [31:0]       mask_q;
  logic [n_rw-1:0]   wr_sel;
  logic [31:0]       clr;
  logic [31:0]       rd_mux;
  logic [31:0]       pipe_dat [read_latency];
  logic [read_latency-1:0] pipe_vld;

  assign hit    = lb_strobe && (lb_addr[23:8] == base_addr);
  assign wr_hit = hit && !lb_rd;
  assign rd_hit = hit && lb_rd;
  assign offset = lb_addr[7:0];
  assign clr    = (wr_hit && offset == off_sticky) ? lb_wdata : 32'h0;

  // Flatten the RW register array onto the packed output bus.
  for (genvar g = 0; g < n_rw; g++) begin : g_rw_out
    assign rw_out[32*g +: 32] = rw_q[g];
  end

  // Decode which RW register (if any) this cycle's write targets.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < n_rw; k++) begin
      if (wr_hit && offset == 8'(k)) wr_sel[k] = 1'b1;
    end
  end

  // Read mux over current register state; unmapped offsets return zero.
  always_comb begin
    rd_mux = 32'h0;
    for (int k = 0; k < n_rw; k++) begin
      if (offset == 8'(k)) rd_mux = rw_q[k];
    end
    for (int k = 0; k < n_ro; k++) begin
      if (offset == 8'(16 + k)) rd_mux = ro_in[32*k +: 32];
    end
    if (offset == off_sticky) rd_mux = sticky_q;
    if (offset == off_mask)   rd_mux = mask_q;
    if (offset == off_id)     rd_mux = id_word;
  end

  // RW registers and their one-cycle write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < n_rw; k++) rw_q[k] <= 32'h0;
      wr_pulse <= '0;
    end else begin
      for (int k = 0; k < n_rw; k++) begin
        if (wr_sel[k]) rw_q[k] <= lb_wdata;
      end
      wr_pulse <= wr_sel;
    end
  end

  // Sticky event bits (set beats clear), mask register and registered interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 32'h0;
      mask_q   <= 32'h0;
      irq      <= 1'b0;
    end else begin
      sticky_q <= (sticky_q & ~clr) | event_in;
      if (wr_hit && offset == off_mask) mask_q <= lb_wdata;
      irq <= |(sticky_q & mask_q);
    end
  end

  // Fixed-length read pipe; data stages only load behind a valid so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < read_latency; i++) pipe_dat[i] <= 32'h0;
    end else begin
      pipe_vld[0] <= rd_hit;
      if (rd_hit) pipe_dat[0] <= rd_mux;
      for (int i = 1; i < read_latency; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign lb_rvalid = pipe_vld[read_latency-1];
  assign lb_rdata  = pipe_dat[read_latency-1];

endmodule
